dual_issue_scheduler: RTL
=========================

Name: dual_issue_scheduler

Overview:
In-order issue buffer and pair scheduler in front of the dual-lane ExecuteUnit.
- Front end: decode pushes up to two decoded instructions per cycle into a circular queue.
- Back end: each cycle, up to two instructions go out from the queue head on ALU lane 1 (older) and lane 2 (younger), with intra-pair hazard checks.
- Flushes everything on a taken branch reported by execute. Holds its outputs while execute stalls.

Parameters:
DEPTH, 8, queue entries; power of two, at least 4.
PAYLOAD_W, 48, opaque per-instruction bits forwarded to execute (aluControl, isBranch/isRet/isBeq/isBgt, branchTarget low bits, etc.).
RAW, 4, register-index width.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset; asynchronous, active-high.
in_valid_k  in  1  decode slot k (k=1,2) holds an instruction; slot 2 is ignored when in_valid_1=0.
in_ready  out  1  queue accepts a full pair this cycle; combinational, asserted when count <= DEPTH-2.
in_pc_k  in  32  PC of slot k.
in_payload_k  in  PAYLOAD_W  opaque control/operand bits for slot k.
in_rs1_k, in_rs2_k, in_rd_k  in  RAW each  source and destination register indices.
in_we_k  in  1  slot k writes in_rd_k.
in_br_k  in  1  slot k is a branch, call or return.
exe_stall  in  1  execute cannot accept new instructions this cycle.
flush  in  1  taken branch or return resolved in execute (OR of isBranchTaken1/2).
iss_valid_k  out  1  lane k carries a valid instruction.
iss_pc_k  out  32  lane k PC.
iss_payload_k  out  PAYLOAD_W  lane k payload.
occupancy  out  log2(DEPTH)+1  current entry count.
split_cnt  out  16  number of cycles where two entries were queued but only one issued; saturates at 16'hFFFF.

Behaviour:
- Reset, asynchronous: pointers=0, count=0, all iss_* = 0, split_cnt=0. in_ready=1 while in reset.
- Enqueue on a rising edge when in_ready && in_valid_1 && !flush.
  - Slot 1 is written at tail, slot 2 at tail+1 if in_valid_2.
  - Tail advances by 1 or 2, modulo DEPTH.
  - in_ready uses the pre-edge count, so it is conservative when a pop happens in the same cycle.
- Issue decision is combinational over head and head+1; outputs are registered.
  - Entry accepted at edge E can appear on iss_* no earlier than edge E+1.
- On an edge with !exe_stall && !flush:
  - count=0: iss_valid_1=iss_valid_2=0.
  - count>=1: head goes to lane 1 and is popped.
  - Lane 2 takes head+1 only if all hold:
    - count>=2;
    - head is not a branch (in_br=0), so nothing younger issues in a branch shadow;
    - no RAW: head.we && head.rd!=0 && (head+1.rs1==head.rd || head+1.rs2==head.rd) is false;
    - no WAW: head.we && head+1.we && head.rd==head+1.rd && rd!=0 is false.
  - Otherwise iss_valid_2=0 and only one entry pops.
  - split_cnt increments when count>=2 and lane 2 is withheld.
- exe_stall=1 (without flush): iss_* hold their values, no pop, split_cnt unchanged. Enqueue still proceeds.
- flush=1: head=tail=count=0 and all iss_valid=0 at that edge. Flush dominates stall and enqueue; same-cycle inputs are dropped. split_cnt is kept.
- Register 0 never creates a hazard.
- Simultaneous enqueue and pop: count_next = count + pushed - popped. count never exceeds DEPTH.
- Pointer wrap at DEPTH-1 → 0 must be seamless, including a pair that straddles the wrap.

Decomposition:
- Shared header issue_defs: DEPTH, PAYLOAD_W, RAW defaults, and localparam bit offsets of the packed queue entry {pc, payload, rs1, rs2, rd, we, br}.
- Sub-module issue_fifo: dual-write, dual-read-port circular buffer with push count 0/1/2, pop count 0/1/2, clear, and count output.
- Pairing and hazard logic, output registers and split_cnt live in dual_issue_scheduler.

Test Plan:
- Reset then enqueue independent pair (pc 0x00/0x04; rd 1,2; rs 3,4) → next edge iss_valid_1=iss_valid_2=1, iss_pc_1=0x00, iss_pc_2=0x04, occupancy=0.
- RAW pair: slot1 rd=5 we=1, slot2 rs1=5 → lane 1 only (pc 0x08), then pc 0x0C on lane 1 next cycle; split_cnt=1.
- Branch at head (pc 0x10 br=1) followed by 0x14 → 0x10 issues alone; assert flush on the following cycle → iss_valid both 0, occupancy=0, 0x14 never issued.
- Fill with 4 pairs while exe_stall=1 (DEPTH=8) → in_ready=0 at occupancy 8, iss_* frozen; release stall → pops of 2 per cycle, in_ready back to 1 when occupancy=6.
- Wrap-around: 7 single pushes and pops to move head to 7, then push pair 0x40/0x44 → issued together from slots 7 and 0.
- Async rst asserted mid-stream with occupancy 5 → all outputs 0 immediately, in_ready=1.

Source files
------------

// File: rtl/dual_issue_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// dual_issue_scheduler_pkg : shared defaults and packed queue-entry layout
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dual_issue_scheduler_pkg;

  localparam int DEPTH_DEF     = 8;
  localparam int PAYLOAD_W_DEF = 48;
  localparam int RAW_DEF       = 4;

  // Entry layout, MSB to LSB: {pc, payload, rs1, rs2, rd, we, br}
  localparam int BR_OFS = 0;
  localparam int WE_OFS = 1;
  localparam int RD_OFS = 2;

  function automatic int rs2_ofs(input int raw);
    return RD_OFS + raw;
  endfunction

  function automatic int rs1_ofs(input int raw);
    return RD_OFS + 2 * raw;
  endfunction

  function automatic int pay_ofs(input int raw);
    return RD_OFS + 3 * raw;
  endfunction

  function automatic int pc_ofs(input int raw, input int pw);
    return pay_ofs(raw) + pw;
  endfunction

  function automatic int entry_w(input int raw, input int pw);
    return pc_ofs(raw, pw) + 32;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dual_issue_scheduler_fifo.sv
// ---------------------------------------------------------------------------
// issue_fifo : circular buffer, two write ports at tail, two read ports at head
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module issue_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic [1:0]               push_cnt,
  input  logic [W-1:0]             wdata_1,
  input  logic [W-1:0]             wdata_2,
  input  logic [1:0]               pop_cnt,
  output logic [W-1:0]             rdata_1,
  output logic [W-1:0]             rdata_2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW-1:0] head_p1;
  logic [AW-1:0] tail_p1;

  // Power-of-two depth lets pointer arithmetic wrap by truncation
  assign head_p1 = head + 1'b1;
  assign tail_p1 = tail + 1'b1;

  assign rdata_1 = mem[head];
  assign rdata_2 = mem[head_p1];

  always_ff @(posedge clk) begin
    if (!clear) begin
      if (push_cnt != 2'd0) mem[tail] <= wdata_1;
      if (push_cnt == 2'd2) mem[tail_p1] <= wdata_2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(pop_cnt);
      tail  <= tail + AW'(push_cnt);
      count <= count + CW'(push_cnt) - CW'(pop_cnt);
    end
  end

endmodule

`default_nettype wire

// File: rtl/dual_issue_scheduler.sv
// ---------------------------------------------------------------------------
// dual_issue_scheduler : in-order issue queue with intra-pair hazard pairing
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dual_issue_scheduler #(
  parameter int DEPTH     = dual_issue_scheduler_pkg::DEPTH_DEF,
  parameter int PAYLOAD_W = dual_issue_scheduler_pkg::PAYLOAD_W_DEF,
  parameter int RAW       = dual_issue_scheduler_pkg::RAW_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid_1,
  input  logic                   in_valid_2,
  output logic                   in_ready,
  input  logic [31:0]            in_pc_1,
  input  logic [31:0]            in_pc_2,
  input  logic [PAYLOAD_W-1:0]   in_payload_1,
  input  logic [PAYLOAD_W-1:0]   in_payload_2,
  input  logic [RAW-1:0]         in_rs1_1,
  input  logic [RAW-1:0]         in_rs2_1,
  input  logic [RAW-1:0]         in_rd_1,
  input  logic [RAW-1:0]         in_rs1_2,
  input  logic [RAW-1:0]         in_rs2_2,
  input  logic [RAW-1:0]         in_rd_2,
  input  logic                   in_we_1,
  input  logic                   in_we_2,
  input  logic                   in_br_1,
  input  logic                   in_br_2,
  input  logic                   exe_stall,
  input  logic                   flush,
  output logic                   iss_valid_1,
  output logic                   iss_valid_2,
  output logic [31:0]            iss_pc_1,
  output logic [31:0]            iss_pc_2,
  output logic [PAYLOAD_W-1:0]   iss_payload_1,
  output logic [PAYLOAD_W-1:0]   iss_payload_2,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [15:0]            split_cnt
);

  import dual_issue_scheduler_pkg::*;

  localparam int CW      = $clog2(DEPTH) + 1;
  localparam int EW      = entry_w(RAW, PAYLOAD_W);
  localparam int RS1_OFS = rs1_ofs(RAW);
  localparam int RS2_OFS = rs2_ofs(RAW);
  localparam int PAY_OFS = pay_ofs(RAW);
  localparam int PC_OFS  = pc_ofs(RAW, PAYLOAD_W);

  logic [EW-1:0] ent_1;
  logic [EW-1:0] ent_2;
  logic [EW-1:0] head_ent;
  logic [EW-1:0] next_ent;
  logic [CW-1:0] count;
  logic [1:0]    push_cnt;
  logic [1:0]    pop_cnt;
  logic          fire;
  logic          raw_hz;
  logic          waw_hz;
  logic          head_rd_nz;
  logic          pair_ok;
  logic          unused_ok;

  assign ent_1 = {in_pc_1, in_payload_1, in_rs1_1, in_rs2_1, in_rd_1, in_we_1, in_br_1};
  assign ent_2 = {in_pc_2, in_payload_2, in_rs1_2, in_rs2_2, in_rd_2, in_we_2, in_br_2};

  // Conservative: uses the pre-edge count even if a pop lands on the same edge
  assign in_ready  = (count <= CW'(DEPTH - 2));
  assign push_cnt  = (in_ready && in_valid_1 && !flush) ? (in_valid_2 ? 2'd2 : 2'd1) : 2'd0;
  assign fire      = !exe_stall && !flush;
  assign occupancy = count;

  assign head_rd_nz = (head_ent[RD_OFS +: RAW] != '0);
  assign raw_hz = head_ent[WE_OFS] && head_rd_nz &&
                  ((next_ent[RS1_OFS +: RAW] == head_ent[RD_OFS +: RAW]) ||
                   (next_ent[RS2_OFS +: RAW] == head_ent[RD_OFS +: RAW]));
  assign waw_hz = head_ent[WE_OFS] && next_ent[WE_OFS] && head_rd_nz &&
                  (next_ent[RD_OFS +: RAW] == head_ent[RD_OFS +: RAW]);
  assign pair_ok = (count >= CW'(2)) && !head_ent[BR_OFS] && !raw_hz && !waw_hz;

  always_comb begin
    pop_cnt = 2'd0;
    if (fire && (count != '0)) pop_cnt = pair_ok ? 2'd2 : 2'd1;
  end

  assign unused_ok = ^{head_ent[RS1_OFS +: RAW], head_ent[RS2_OFS +: RAW], next_ent[BR_OFS]};

  issue_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clear    (flush),
    .push_cnt (push_cnt),
    .wdata_1  (ent_1),
    .wdata_2  (ent_2),
    .pop_cnt  (pop_cnt),
    .rdata_1  (head_ent),
    .rdata_2  (next_ent),
    .count    (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_valid_1   <= 1'b0;
      iss_valid_2   <= 1'b0;
      iss_pc_1      <= '0;
      iss_pc_2      <= '0;
      iss_payload_1 <= '0;
      iss_payload_2 <= '0;
      split_cnt     <= '0;
    end else if (flush) begin
      iss_valid_1 <= 1'b0;
      iss_valid_2 <= 1'b0;
    end else if (!exe_stall) begin
      iss_valid_1   <= (count != '0);
      iss_valid_2   <= pair_ok;
      iss_pc_1      <= head_ent[PC_OFS +: 32];
      iss_pc_2      <= next_ent[PC_OFS +: 32];
      iss_payload_1 <= head_ent[PAY_OFS +: PAYLOAD_W];
      iss_payload_2 <= next_ent[PAY_OFS +: PAYLOAD_W];
      if ((count >= CW'(2)) && !pair_ok && (split_cnt != 16'hFFFF))
        split_cnt <= split_cnt + 16'd1;
    end
  end

endmodule

`default_nettype wire
